gene_sweep_ctrl: RTL and testbench

//  Sequencer for the gene-network simulator: sweeps every initial state 0..2^N-1, loads each into the network,

---
 rtl/gene_sweep_ctrl_if.sv | 39 +++
 rtl/gene_sweep_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_gene_sweep_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gene_sweep_ctrl_if.sv
// gene_sweep_ctrl_if
//   Bus between the sweep sequencer, the gene-network state register and the
//   result consumer.
//   master : sequencer side (drives load/step/init_val and the result record,
//            reads the network state x and the consumer's result_ready)
//   slave  : network + consumer side
//   Signals
//     load, step     network control (never both high)
//     init_val [N]   init value currently being simulated
//     x        [N]   current network state, registered in the network
//     result_valid / result_ready   record handshake
//     result_init [N], result_kind [2], result_state [N], result_steps [CW]
interface gene_sweep_ctrl_if #(
  parameter int N  = 8,
  parameter int CW = 5
);
  logic          load;
  logic          step;
  logic [N-1:0]  init_val;
  logic [N-1:0]  x;
  logic          result_valid;
  logic          result_ready;
  logic [N-1:0]  result_init;
  logic [1:0]    result_kind;
  logic [N-1:0]  result_state;
  logic [CW-1:0] result_steps;

  modport master (
    output load, step, init_val,
    output result_valid, result_init, result_kind, result_state, result_steps,
    input  x, result_ready
  );

  modport slave (
    input  load, step, init_val,
    input  result_valid, result_init, result_kind, result_state, result_steps,
    output x, result_ready
  );
endinterface

// File: rtl/gene_sweep_ctrl.sv
// gene_sweep_ctrl
//   Sequencer for the gene-network simulator. Sweeps every initial state
//   0..2^N-1: loads it into the network, steps the network, and classifies the
//   trajectory as fixed point, period-2 cycle or timeout. One result record per
//   init value is offered over a valid/ready handshake.
//   Ports
//     clk     clock, all state on posedge
//     rst     asynchronous active-high reset
//     start   begin a sweep (honoured in IDLE only)
//     bus     gene_sweep_ctrl_if.master (load/step/init_val/x, result record)
//     busy    high in every state except IDLE
//     done    one-cycle pulse after the last record is accepted
//   Optional feature (macro GENE_SWEEP_STATS_EN):
//     cnt_fixed, cnt_cycle, cnt_timeout [N+1] per-kind record counters,
//     cleared on rst and on start, counted on each record transfer.
//   Result kinds: 00 fixed point, 01 period-2 cycle, 10 timeout.
module gene_sweep_ctrl #(
  parameter int N         = 8,
  parameter int MAX_STEPS = 16,
  parameter int CW        = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  gene_sweep_ctrl_if.master       bus,
  output logic                    busy,
  output logic                    done
`ifdef GENE_SWEEP_STATS_EN
  ,
  output logic [N:0]              cnt_fixed,
  output logic [N:0]              cnt_cycle,
  output logic [N:0]              cnt_timeout
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_REPORT,
    S_FIN
  } state_t;

  localparam logic [1:0] KIND_FIXED   = 2'b00;
  localparam logic [1:0] KIND_CYCLE   = 2'b01;
  localparam logic [1:0] KIND_TIMEOUT = 2'b10;

  state_t        state_q, state_d;

  logic [N-1:0]  init_q;
  logic [N-1:0]  h1_q;      // x one step ago
  logic [N-1:0]  h2_q;      // x two steps ago
  logic [CW-1:0] k_q;       // steps taken since load

  logic          valid_q;
  logic [N-1:0]  res_init_q;
  logic [1:0]    res_kind_q;
  logic [N-1:0]  res_state_q;
  logic [CW-1:0] res_steps_q;

  logic          fixed_hit;
  logic          cycle_hit;
  logic          timeout_hit;
  logic          hit;
  logic          xfer;
  logic          last_init;
  logic [1:0]    hit_kind;

  // ------------------------------------------------------------------
  // Trajectory classification (only meaningful in RUN)
  // ------------------------------------------------------------------
  // History registers are stale right after LOAD; the k guards make the
  // stale values irrelevant, so they need no clearing at load time.
  always_comb begin
    fixed_hit   = (k_q != '0) && (bus.x == h1_q);
    cycle_hit   = (k_q > CW'(1)) && (bus.x == h2_q) && (bus.x != h1_q);
    timeout_hit = (k_q == CW'(MAX_STEPS)) && !fixed_hit && !cycle_hit;
    hit         = (state_q == S_RUN) && (fixed_hit || cycle_hit || timeout_hit);

    if (fixed_hit)      hit_kind = KIND_FIXED;
    else if (cycle_hit) hit_kind = KIND_CYCLE;
    else                hit_kind = KIND_TIMEOUT;
  end

  assign xfer      = valid_q && bus.result_ready;
  assign last_init = (init_q == '1);

  // ------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ------------------------------------------------------------------
  // FSM next state and control outputs
  // ------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    bus.load = 1'b0;
    bus.step = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        bus.load = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        // The network is frozen on the classifying cycle so x stays the
        // reported state.
        bus.step = !hit;
        if (hit) state_d = S_REPORT;
      end
      S_REPORT: begin
        if (xfer) state_d = last_init ? S_FIN : S_LOAD;
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath: init counter, history, step counter, result record
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q      <= '0;
      h1_q        <= '0;
      h2_q        <= '0;
      k_q         <= '0;
      valid_q     <= 1'b0;
      res_init_q  <= '0;
      res_kind_q  <= '0;
      res_state_q <= '0;
      res_steps_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) init_q <= '0;
        end
        S_LOAD: begin
          k_q <= '0;
        end
        S_RUN: begin
          h1_q <= bus.x;
          h2_q <= h1_q;
          k_q  <= k_q + CW'(1);
          if (hit) begin
            valid_q     <= 1'b1;
            res_init_q  <= init_q;
            res_kind_q  <= hit_kind;
            res_state_q <= bus.x;
            res_steps_q <= k_q;
          end
        end
        S_REPORT: begin
          if (xfer) begin
            valid_q <= 1'b0;
            if (!last_init) init_q <= init_q + N'(1);
          end
        end
        S_FIN: begin
          init_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.init_val     = init_q;
  assign bus.result_valid = valid_q;
  assign bus.result_init  = res_init_q;
  assign bus.result_kind  = res_kind_q;
  assign bus.result_state = res_state_q;
  assign bus.result_steps = res_steps_q;

`ifdef GENE_SWEEP_STATS_EN
  // ------------------------------------------------------------------
  // Per-kind record counters; hold after FIN until the next start
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_fixed   <= '0;
      cnt_cycle   <= '0;
      cnt_timeout <= '0;
    end else if (state_q == S_IDLE && start) begin
      cnt_fixed   <= '0;
      cnt_cycle   <= '0;
      cnt_timeout <= '0;
    end else if (state_q == S_REPORT && xfer) begin
      unique case (res_kind_q)
        KIND_FIXED:   cnt_fixed   <= cnt_fixed + (N+1)'(1);
        KIND_CYCLE:   cnt_cycle   <= cnt_cycle + (N+1)'(1);
        KIND_TIMEOUT: cnt_timeout <= cnt_timeout + (N+1)'(1);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_gene_sweep_ctrl.sv
module tb_gene_sweep_ctrl;
  localparam int N   = 8;
  localparam int CW  = 5;
  localparam int MS  = 16;

  localparam int M_ID    = 0;  // f(s) = s
  localparam int M_NOT   = 1;  // f(s) = ~s
  localparam int M_INC   = 2;  // f(s) = s + 1
  localparam int M_MIXED = 3;  // f(s) = s for even s, ~s for odd s

  typedef struct {
    logic [N-1:0]  init;
    logic [1:0]    kind;
    logic [N-1:0]  st;
    logic [CW-1:0] steps;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rdy = 1'b1;
  logic busy, done;
  logic [N-1:0] net_x;
  int mode = M_ID;

  int tests = 0;
  int fails = 0;

  rec_t exp_q[$];
  bit   chk_en = 1'b0;
  bit   expect_done = 1'b0;
  int   m_fixed, m_cycle, m_timeout;

  gene_sweep_ctrl_if #(.N(N), .CW(CW)) bus ();

`ifdef GENE_SWEEP_STATS_EN
  logic [N:0] cnt_fixed, cnt_cycle, cnt_timeout;
`endif

  gene_sweep_ctrl #(.N(N), .MAX_STEPS(MS), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
`ifdef GENE_SWEEP_STATS_EN
    ,
    .cnt_fixed   (cnt_fixed),
    .cnt_cycle   (cnt_cycle),
    .cnt_timeout (cnt_timeout)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] fn(input int m, input logic [N-1:0] s);
    case (m)
      M_ID:    return s;
      M_NOT:   return ~s;
      M_INC:   return s + 8'd1;
      default: return s[0] ? ~s : s;
    endcase
  endfunction

  // Network state register
  always @(posedge clk or posedge rst) begin
    if (rst)               net_x <= '0;
    else if (bus.load)     net_x <= bus.init_val;
    else if (bus.step)     net_x <= fn(mode, net_x);
  end
  assign bus.x            = net_x;
  assign bus.result_ready = rdy;

  // Reference: build the whole trajectory, return the first classification.
  function automatic rec_t model(input int m, input logic [N-1:0] i);
    logic [N-1:0] tr[0:MS];
    rec_t r;
    r.init = i; r.kind = 2'b10; r.st = '0; r.steps = CW'(MS);
    tr[0] = i;
    for (int k = 1; k <= MS; k++) begin
      tr[k] = fn(m, tr[k-1]);
      if (tr[k] == tr[k-1]) begin
        r.kind = 2'b00; r.st = tr[k]; r.steps = CW'(k); return r;
      end
      if (k >= 2 && tr[k] == tr[k-2]) begin
        r.kind = 2'b01; r.st = tr[k]; r.steps = CW'(k); return r;
      end
    end
    r.st = tr[MS];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // Per-cycle checker
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("load_step_overlap", {31'd0, bus.load & bus.step}, 32'd0);
      if (expect_done) begin
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_in_fin", {31'd0, busy}, 32'd1);
        expect_done = 1'b0;
      end else begin
        chk("done_quiet", {31'd0, done}, 32'd0);
      end
      if (bus.result_valid) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_record: got init %0h expected no record", bus.result_init);
        end else begin
          chk("rec_init",  {24'd0, bus.result_init},  {24'd0, exp_q[0].init});
          chk("rec_kind",  {30'd0, bus.result_kind},  {30'd0, exp_q[0].kind});
          chk("rec_state", {24'd0, bus.result_state}, {24'd0, exp_q[0].st});
          chk("rec_steps", {27'd0, bus.result_steps}, {27'd0, exp_q[0].steps});
          chk("rpt_init_val", {24'd0, bus.init_val}, {24'd0, exp_q[0].init});
          chk("rpt_no_ctl", {31'd0, bus.load | bus.step}, 32'd0);
          if (rdy) begin
            if (exp_q[0].init == 8'hFF) expect_done = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic push_sweep(input int m);
    rec_t r;
    m_fixed = 0; m_cycle = 0; m_timeout = 0;
    for (int i = 0; i < 256; i++) begin
      r = model(m, 8'(i));
      exp_q.push_back(r);
      case (r.kind)
        2'b00:   m_fixed++;
        2'b01:   m_cycle++;
        default: m_timeout++;
      endcase
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_load"},  {31'd0, bus.load}, 32'd0);
    chk({tag, "_step"},  {31'd0, bus.step}, 32'd0);
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
    chk({tag, "_done"},  {31'd0, done}, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.result_valid}, 32'd0);
    chk({tag, "_init"},  {24'd0, bus.init_val}, 32'd0);
    chk({tag, "_rstate"}, {24'd0, bus.result_state}, 32'd0);
`ifdef GENE_SWEEP_STATS_EN
    chk({tag, "_cntf"}, {23'd0, cnt_fixed}, 32'd0);
`endif
  endtask

  // bp_init < 0: no backpressure
  task automatic run_sweep(input int m, input int bp_init);
    int  budget;
    bit  bp_done;
    mode = m;
    rdy = 1'b1;
    push_sweep(m);
    chk_en = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("first_load", {31'd0, bus.load}, 32'd1);
    budget = 0; bp_done = (bp_init < 0);
    while ((exp_q.size() != 0 || busy) && budget < 20000) begin
      cyc(); budget++;
      if (!bp_done && bus.result_valid && bus.init_val == 8'(bp_init)) begin
        rdy = 1'b0;
        repeat (10) cyc();
        chk("bp_init_hold", {24'd0, bus.init_val}, bp_init);
        chk("bp_valid_hold", {31'd0, bus.result_valid}, 32'd1);
        rdy = 1'b1;
        bp_done = 1'b1;
      end
    end
    if (budget >= 20000) begin
      tests++; fails++;
      $display("FAIL sweep_timeout: got %0d records left expected 0", exp_q.size());
    end
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_wrap_init", {24'd0, bus.init_val}, 32'd0);
`ifdef GENE_SWEEP_STATS_EN
    repeat (3) cyc();
    chk("cnt_fixed",   {23'd0, cnt_fixed},   m_fixed);
    chk("cnt_cycle",   {23'd0, cnt_cycle},   m_cycle);
    chk("cnt_timeout", {23'd0, cnt_timeout}, m_timeout);
`endif
    chk_en = 1'b0;
  endtask

  initial begin
    rec_t r;
    int budget;

    // Pin the model with hand-computed trajectories
    r = model(M_ID, 8'h05);
    chk("pin_id",    {r.kind, r.st, r.steps}, {2'b00, 8'h05, 5'd1});
    r = model(M_NOT, 8'h12);
    chk("pin_not",   {r.kind, r.st, r.steps}, {2'b01, 8'h12, 5'd2});
    r = model(M_INC, 8'hF8);
    chk("pin_inc",   {r.kind, r.st, r.steps}, {2'b10, 8'h08, 5'd16});
    r = model(M_MIXED, 8'h03);
    chk("pin_mixed", {r.kind, r.st, r.steps}, {2'b00, 8'hFC, 5'd2});
    r = model(M_MIXED, 8'h40);
    chk("pin_mixed_even", {r.kind, r.st, r.steps}, {2'b00, 8'h40, 5'd1});

    repeat (3) cyc();
    check_idle("reset");
    rst = 1'b0;
    repeat (2) cyc();
    check_idle("post_reset");

    run_sweep(M_ID, -1);
    run_sweep(M_NOT, -1);
    run_sweep(M_INC, 5);
    run_sweep(M_MIXED, -1);

    // Reset in the middle of RUN for init 0x37
    mode = M_ID;
    push_sweep(M_ID);
    chk_en = 1'b1;
    start = 1'b1; cyc(); start = 1'b0;
    budget = 0;
    while (!(bus.init_val == 8'h37 && bus.step) && budget < 5000) begin
      cyc(); budget++;
    end
    chk("reach_0x37", {24'd0, bus.init_val}, 32'h37);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    exp_q.delete();
    expect_done = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    check_idle("after_rst");

    run_sweep(M_ID, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
